// File: rtl/spi_regs_pkg.sv
// ============================================================================
// Module      : spi_regs_pkg
// Description : Shared types and constants for the SPI MISO register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_regs_pkg;

  // Default bank geometry: 16 words of 32 bits
  localparam int BANK_ADDR_W = 4;
  localparam int BANK_DEPTH  = 2 ** BANK_ADDR_W;
  localparam int WORD_W      = 32;

  // Named register slots as seen by the Pi
  localparam logic [BANK_ADDR_W-1:0] SLOT_HPS       = 4'd0;
  localparam logic [BANK_ADDR_W-1:0] SLOT_SPEED     = 4'd1;
  localparam logic [BANK_ADDR_W-1:0] SLOT_TIMESTAMP = 4'd15;

  // Write-port controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  // Successor of idx in a ring of n entries
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first active
//               request at or after the pointer, searching upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import spi_regs_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan the ring starting at ptr and stop at the first active request
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_miso_reg_arbiter.sv
// ============================================================================
// Module      : spi_miso_reg_arbiter
// Description : FPGA-to-Pi register bank read by spi_slave on the MISO side.
//               One write port shared round-robin between N_REQ requesters
//               with a valid/ready handshake; writes are held off while the
//               SPI chip select is active so a word is never torn.
//               Optional macro SPI_MISO_TIMESTAMP_EN: a free-running counter
//               is captured into the top bank word on every CS falling edge,
//               and requester writes to that word are acknowledged but dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_miso_reg_arbiter
  import spi_regs_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = BANK_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     spi_cs_sync,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [15:0]              wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(N_REQ);

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic [N_REQ-1:0]    ready_q;
  logic [15:0]         count_q;
  logic [DATA_W-1:0]   bank [DEPTH];

  logic [ADDR_W-1:0]   addr_arr [N_REQ];
  logic [DATA_W-1:0]   data_arr [N_REQ];

  logic [N_REQ-1:0]    arb_grant;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_any;

  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_keep;

  // Split the packed request buses into per-requester words
  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Address and data of the granted requester, sampled during WRITE
  assign wr_addr = addr_arr[grant_idx];
  assign wr_data = data_arr[grant_idx];

`ifdef SPI_MISO_TIMESTAMP_EN
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  logic [31:0] ts_count;
  logic        cs_q;
  logic        cs_fall;

  // Free-running timestamp and registered chip select for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_count <= '0;
      cs_q     <= 1'b1;
    end else begin
      ts_count <= ts_count + 32'd1;
      cs_q     <= spi_cs_sync;
    end
  end

  assign cs_fall = cs_q & ~spi_cs_sync;
  // The top word belongs to the timestamp; requester data for it is dropped
  assign wr_keep = (wr_addr != TOP_ADDR);
`else
  assign wr_keep = 1'b1;
`endif

  // Controller FSM, round-robin pointer, commit counter and bank storage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      ready_q   <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      ready_q <= '0;
      case (state)
        IDLE: begin
          if (!spi_cs_sync) begin
            state <= FREEZE;
          end else if (arb_any) begin
            grant_idx <= arb_idx;
            ready_q   <= arb_grant;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (wr_keep) bank[wr_addr] <= wr_data;
          count_q <= count_q + 16'd1;
          ptr     <= PTR_W'(next_index(int'(grant_idx), N_REQ));
          state   <= spi_cs_sync ? IDLE : FREEZE;
        end
        FREEZE: begin
          if (spi_cs_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef SPI_MISO_TIMESTAMP_EN
      if (cs_fall) bank[TOP_ADDR] <= DATA_W'(ts_count);
`endif
    end
  end

  // An aborted write must not be acknowledged, or the requester would drop
  // data that never reached the bank; reset masks the pulse immediately.
  assign req_ready = ready_q & {N_REQ{reset_n}};
  assign rd_data   = bank[rd_addr];
  assign wr_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_miso_reg_arbiter.sv
// ============================================================================
// Module      : tb_spi_miso_reg_arbiter
// Description : Self-checking bench for spi_miso_reg_arbiter with a
//               behavioural model of the bank, commit count and rotation.
//               Timestamp scenario is built when SPI_MISO_TIMESTAMP_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_spi_miso_reg_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int D  = 2 ** AW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            spi_cs_sync;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic [15:0]     wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DW-1:0] m_bank [D];
  int            m_ptr;
  int            m_count;

  spi_miso_reg_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .spi_cs_sync (spi_cs_sync),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    spi_cs_sync = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    rd_addr     = '0;
    reset_n     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < D; i++) m_bank[i] = '0;
    m_ptr   = 0;
    m_count = 0;
  endtask

  // First valid requester at or after p, with wrap-around
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int d = 0; d < N; d++) begin
      if (v[(p + d) % N]) return (p + d) % N;
    end
    return -1;
  endfunction

  // Apply a committed write of requester g to the model
  task automatic model_commit(input int g);
    logic [AW-1:0] a;
    a = req_addr[g*AW +: AW];
`ifdef SPI_MISO_TIMESTAMP_EN
    if (a != AW'(D - 1)) m_bank[a] = req_data[g*DW +: DW];
`else
    m_bank[a] = req_data[g*DW +: DW];
`endif
    m_count = m_count + 1;
    m_ptr   = (g + 1) % N;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < D; a++) begin
      rd_addr = AW'(a);
      #1;
      n_cmp++;
      if (rd_data !== '0) begin
        n_bad++;
        $display("FAIL reset_bank[%0d]: got %h want 0", a, rd_data);
      end
    end
    n_cmp++;
    if (wr_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_wr_count: got %0d want 0", wr_count);
    end
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 4'd3, 32'hDEADBEEF);
    step();
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_ready: got %b want 0010", req_ready);
    end
    model_commit(1);
    step();
    req_valid = '0;
    rd_addr   = 4'd3;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_ready_once: got %b want 0000", req_ready);
    end
    n_cmp++;
    if (rd_data !== m_bank[3]) begin
      n_bad++;
      $display("FAIL single_data: got %h want %h", rd_data, m_bank[3]);
    end
    n_cmp++;
    if (wr_count !== 16'(m_count)) begin
      n_bad++;
      $display("FAIL single_count: got %0d want %0d", wr_count, m_count);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(8 + i), $urandom);
    exp = 0;
    for (int k = 0; k < 2 * N; k++) begin
      step();
      n_cmp++;
      if (req_ready !== (N'(1) << exp)) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, N'(1) << exp);
      end
      model_commit(exp);
      step();
      n_cmp++;
      if (req_ready !== '0) begin
        n_bad++;
        $display("FAIL rr_gap[%0d]: got %b want 0", k, req_ready);
      end
      req_data[exp*DW +: DW] = $urandom;
      exp = (exp + 1) % N;
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(8 + i);
      #1;
      n_cmp++;
      if (rd_data !== m_bank[8 + i]) begin
        n_bad++;
        $display("FAIL rr_data[%0d]: got %h want %h", 8 + i, rd_data, m_bank[8 + i]);
      end
    end
    n_cmp++;
    if (wr_count !== 16'(m_count)) begin
      n_bad++;
      $display("FAIL rr_count: got %0d want %0d", wr_count, m_count);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    spi_cs_sync = 1'b0;
    step();
    step();
    set_req(2, 4'd7, $urandom);
    rd_addr = 4'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (req_ready !== '0 || rd_data !== '0) begin
        n_bad++;
        $display("FAIL freeze_hold[%0d]: got ready %b data %h want 0 0", k, req_ready, rd_data);
      end
    end
    spi_cs_sync = 1'b1;
    step();
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++;
      $display("FAIL freeze_exit_c1: got %b want 0", req_ready);
    end
    step();
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL freeze_exit_c2: got %b want 0100", req_ready);
    end
    model_commit(2);
    step();
    req_valid = '0;
    n_cmp++;
    if (rd_data !== m_bank[7]) begin
      n_bad++;
      $display("FAIL freeze_data: got %h want %h", rd_data, m_bank[7]);
    end
  endtask

  task automatic test_cs_during_write();
    do_reset();
    set_req(0, 4'd2, $urandom);
    step();
    model_commit(0);
    spi_cs_sync = 1'b0;
    step();
    req_data[0 +: DW] = $urandom;
    rd_addr = 4'd2;
    #1;
    n_cmp++;
    if (rd_data !== m_bank[2]) begin
      n_bad++;
      $display("FAIL cswr_completed: got %h want %h", rd_data, m_bank[2]);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (req_ready !== '0) begin
        n_bad++;
        $display("FAIL cswr_frozen[%0d]: got %b want 0", k, req_ready);
      end
    end
    spi_cs_sync = 1'b1;
    step();
    step();
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL cswr_resume: got %b want 0001", req_ready);
    end
    model_commit(0);
    step();
    req_valid = '0;
    n_cmp++;
    if (rd_data !== m_bank[2] || wr_count !== 16'(m_count)) begin
      n_bad++;
      $display("FAIL cswr_second: got %h/%0d want %h/%0d", rd_data, wr_count, m_bank[2], m_count);
    end
  endtask

  task automatic test_abort_reset();
    do_reset();
    set_req(0, 4'd5, 32'h0000_1234);
    step();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++;
      $display("FAIL abort_ready: got %b want 0", req_ready);
    end
    step();
    req_valid = '0;
    rd_addr   = 4'd5;
    #1;
    n_cmp++;
    if (rd_data !== '0 || wr_count !== 16'd0) begin
      n_bad++;
      $display("FAIL abort_bank: got %h/%0d want 0/0", rd_data, wr_count);
    end
    reset_n = 1'b1;
    for (int i = 0; i < D; i++) m_bank[i] = '0;
    m_ptr = 0;
    m_count = 0;
    set_req(3, 4'd6, $urandom);
    step();
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL abort_idle: got %b want 1000", req_ready);
    end
    model_commit(3);
    step();
    req_valid = '0;
    rd_addr   = 4'd6;
    #1;
    n_cmp++;
    if (rd_data !== m_bank[6]) begin
      n_bad++;
      $display("FAIL abort_after: got %h want %h", rd_data, m_bank[6]);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    set_req(0, 4'd4, 32'hAAAA_0000);
    set_req(1, 4'd4, 32'hBBBB_1111);
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (req_ready !== (N'(1) << k)) begin
        n_bad++;
        $display("FAIL same_grant[%0d]: got %b want %b", k, req_ready, N'(1) << k);
      end
      model_commit(k);
      step();
      req_valid[k] = 1'b0;
    end
    rd_addr = 4'd4;
    #1;
    n_cmp++;
    if (rd_data !== m_bank[4]) begin
      n_bad++;
      $display("FAIL same_last_wins: got %h want %h", rd_data, m_bank[4]);
    end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(1, 0) == 1) set_req(i, AW'($urandom), $urandom);
    end
    if (req_valid == '0) set_req(0, AW'($urandom), $urandom);
    for (int k = 0; k < 40; k++) begin
      g = model_grant(req_valid, m_ptr);
      step();
      n_cmp++;
      if (req_ready !== (N'(1) << g)) begin
        n_bad++;
        $display("FAIL rand_grant[%0d]: got %b want %b", k, req_ready, N'(1) << g);
      end
      model_commit(g);
      step();
      n_cmp++;
      if (req_ready !== '0) begin
        n_bad++;
        $display("FAIL rand_gap[%0d]: got %b want 0", k, req_ready);
      end
      if ($urandom_range(1, 0) == 1) req_valid[g] = 1'b0;
      else set_req(g, AW'($urandom), $urandom);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(3, 0) == 0) set_req(i, AW'($urandom), $urandom);
      end
      if (req_valid == '0) set_req($urandom_range(N - 1, 0), AW'($urandom), $urandom);
      rd_addr = AW'($urandom);
      #1;
      n_cmp++;
      if (rd_data !== m_bank[rd_addr] || wr_count !== 16'(m_count)) begin
        n_bad++;
        $display("FAIL rand_state[%0d]: got %h/%0d want %h/%0d", k, rd_data, wr_count,
                 m_bank[rd_addr], m_count);
      end
    end
    req_valid = '0;
  endtask

`ifdef SPI_MISO_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    // Counter reaches 100 after 100 edges out of reset
    for (int k = 0; k < 100; k++) step();
    spi_cs_sync = 1'b0;
    step();
    m_bank[D - 1] = 32'd100;
    rd_addr = AW'(D - 1);
    #1;
    n_cmp++;
    if (rd_data !== m_bank[D - 1]) begin
      n_bad++;
      $display("FAIL ts_capture: got %0d want %0d", rd_data, m_bank[D - 1]);
    end
    spi_cs_sync = 1'b1;
    step();
    set_req(0, AW'(D - 1), 32'h55);
    step();
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL ts_ack: got %b want 0001", req_ready);
    end
    model_commit(0);
    step();
    req_valid = '0;
    #1;
    n_cmp++;
    if (rd_data !== m_bank[D - 1] || wr_count !== 16'(m_count)) begin
      n_bad++;
      $display("FAIL ts_discard: got %0d/%0d want %0d/%0d", rd_data, wr_count,
               m_bank[D - 1], m_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_freeze();
    test_cs_during_write();
    test_abort_reset();
    test_same_addr();
    test_random();
`ifdef SPI_MISO_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_miso_reg_arbiter.md
Name: spi_miso_reg_arbiter

Overview:
- Owns the 16x32 FPGA-to-Pi register bank that the SPI slave reads on the MISO side.
- Shares the single bank write port between N_REQ requesters, such as HPS mailbox, wheel-speed encoders and laser/odometry. Arbitration is round-robin with a valid/ready handshake.
- Stalls all writes while an SPI transaction is in progress, so the word shifted out to the Pi is never torn.
- Sits between the sensor/HPS blocks and spi_slave. spi_slave reads rd_data asynchronously by address.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 4, bank address width (bank depth = 2**ADDR_W).
- DATA_W, 32, bank word width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*ADDR_W  packed target addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-cycle accept pulse per requester.
- spi_cs_sync  in  1  SPI chip select, already synchronised to clk; 1 = idle, 0 = transaction active.
- rd_addr  in  ADDR_W  read address from spi_slave.
- rd_data  out  DATA_W  equals bank[rd_addr]; combinational read.
- wr_count  out  16  number of committed writes; wraps at 0xFFFF.

Behaviour:
- Reset is synchronous: reset_n low at a clk rising edge does all of the following.
  - Every bank word is cleared to 0.
  - State goes to IDLE and the round-robin pointer goes to 0.
  - req_ready goes to 0 and wr_count goes to 0.
  - Reset asserted mid-WRITE aborts that write; no ready pulse is issued.
- States:
  - IDLE, when spi_cs_sync=0: go to FREEZE; no grant.
  - IDLE, when spi_cs_sync=1 and any req_valid is high: latch the grant index, then go to WRITE.
  - Grant index: the first valid requester at or after the pointer, searching upward with wrap-around.
  - WRITE: bank[req_addr[g]] <= req_data[g]; req_ready[g]=1 for exactly this cycle; wr_count increments; pointer becomes (g+1) mod N_REQ.
  - WRITE, next state: FREEZE if spi_cs_sync=0 in this cycle, otherwise IDLE. A granted write always completes.
  - FREEZE: no grants and no bank writes; go to IDLE on the first cycle with spi_cs_sync=1.
- Handshake rules:
  - A requester holds valid, addr and data stable until it sees ready.
  - Dropping valid before ready is illegal; the block's behaviour is then undefined.
  - Address and data are sampled in the WRITE cycle.
- Latency and throughput:
  - Valid first seen in IDLE at edge t produces ready during the cycle after edge t+1, i.e. 1 cycle to grant.
  - Maximum throughput is one write per 2 cycles.
- Simultaneous requests: round-robin from the pointer, so no requester starves. With all N_REQ valid continuously, each is served once every 2*N_REQ cycles.
- Two requesters targeting the same address: both are committed in grant order; the last write wins.
- rd_data is always the current bank content. A WRITE cycle updates it from the next cycle.

Optional Feature:
- Macro: SPI_MISO_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running counter runs; reset value 0, increment 1 per clk, wraps.
  - On the falling edge of spi_cs_sync (1 to 0, detected with a registered copy), bank[2**ADDR_W-1] is loaded with the counter value.
  - Requester writes to that address are still acknowledged (ready pulses, wr_count increments) but the data is discarded.
- When undefined: the top address is an ordinary register and there is no counter logic.

Decomposition:
- Package spi_regs_pkg holds:
  - the state enum (IDLE, WRITE, FREEZE);
  - bank-depth and word-width constants;
  - named slot address constants: HPS=0, SPEED=1, TIMESTAMP=15.
- One sub-module: rr_arbiter. Inputs: request vector and pointer. Outputs: grant one-hot, grant index and any-valid. Purely combinational and reusable.

Test Plan:
- Reset, then drive rd_addr over 0..15 → rd_data=0 for every address and wr_count=0.
- Requester 1 writes addr 3 with 0xDEADBEEF, spi_cs_sync=1 → req_ready[1] pulses once on the 2nd cycle; rd_data at addr 3 reads 0xDEADBEEF on the next cycle; wr_count=1.
- All four requesters valid from pointer 0, distinct addresses → grant order 0,1,2,3 at cycles 2,4,6,8; next round starts at requester 0.
- Hold spi_cs_sync=0, then raise requester 2 → no ready while CS is low. After CS goes high, ready at the 2nd cycle and the bank is updated.
- Reset_n low during WRITE of 0x1234 to addr 5 → no ready; bank[5]=0; state is IDLE.
- With SPI_MISO_TIMESTAMP_EN: CS falls at counter value 100 → bank[15]=100. A requester write of 0x55 to addr 15 is acknowledged and bank[15] stays 100.
